// File: rtl/prog_mod_counter_if.sv
// prog_mod_counter_if: control, serial-load and output bundle for prog_mod_counter.
// The presc field exists only when PROG_MOD_COUNTER_PRESCALE_EN is defined.
interface prog_mod_counter_if #(parameter int WIDTH = 8);
  logic load, ld_lim, sdi, sclk, up, en, oe;
  logic [1:0] mode;
  logic [WIDTH-1:0] count, count_oeb;
  logic tc, done;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
  logic [3:0] presc;
  modport master (output load, ld_lim, sdi, sclk, up, en, mode, oe, presc,
                  input count, count_oeb, tc, done);
  modport slave (input load, ld_lim, sdi, sclk, up, en, mode, oe, presc,
                 output count, count_oeb, tc, done);
`else
  modport master (output load, ld_lim, sdi, sclk, up, en, mode, oe,
                  input count, count_oeb, tc, done);
  modport slave (input load, ld_lim, sdi, sclk, up, en, mode, oe,
                 output count, count_oeb, tc, done);
`endif
endinterface

// File: rtl/prog_mod_counter.sv
// prog_mod_counter: up/down wrap/saturate/one-shot counter with serially loaded count and limit.
// Optional prescaler enabled by PROG_MOD_COUNTER_PRESCALE_EN.
module prog_mod_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            arst_n,
  prog_mod_counter_if.slave bus
);
  logic [SYNC_STAGES-1:0] sclk_sync_q, sdi_sync_q;
  logic                   sclk_prev_q;
  logic [WIDTH-1:0]       shreg_q, lim_q, count_q, count_d, step_val;
  logic                   tc_q, tc_d, done_q, done_d;
  logic                   shift, tick, step, at_top, at_bot, wrap, one_shot, terminal;

  assign shift = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
  logic [3:0] presc_q;
  assign tick = presc_q == bus.presc;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) presc_q <= '0;
    else presc_q <= (bus.load | ~bus.en | tick) ? 4'd0 : presc_q + 4'd1;
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    at_top   = count_q >= lim_q;
    at_bot   = count_q == '0;
    wrap     = ~(bus.mode[1] ^ bus.mode[0]);
    one_shot = bus.mode == 2'b10;
    terminal = bus.up ? at_top : at_bot;
    step     = bus.en & ~done_q & ~bus.load & tick;
    step_val = bus.up ? (at_top ? (wrap ? '0 : count_q) : count_q + WIDTH'(1))
                      : (at_bot ? (wrap ? lim_q : count_q) : count_q - WIDTH'(1));
    count_d  = bus.load ? shreg_q : step ? step_val : count_q;
    done_d   = ~bus.load & (done_q | (step & terminal & one_shot));
    // tc marks only the arrival at the terminal value, never a hold there
    tc_d     = step & (step_val != count_q) & (step_val == (bus.up ? lim_q : '0));
  end

  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      shreg_q     <= '0;
      lim_q       <= '1;
      count_q     <= '0;
      tc_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      if (shift) shreg_q <= {shreg_q[WIDTH-2:0], sdi_sync_q[SYNC_STAGES-1]};
      if (bus.ld_lim) lim_q <= shreg_q;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end

  assign bus.count     = count_q;
  assign bus.count_oeb = {WIDTH{~bus.oe}};
  assign bus.tc        = tc_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_prog_mod_counter.sv
// tb_prog_mod_counter: directed table-driven bench for prog_mod_counter (WIDTH=8, SYNC_STAGES=2).
module tb_prog_mod_counter;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_mod_counter_if #(.WIDTH(8)) bus ();
  prog_mod_counter #(.WIDTH(8), .SYNC_STAGES(2)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  typedef struct {
    logic       up;
    logic       en;
    logic [1:0] mode;
    logic [7:0] cnt;
    logic       tc;
    logic       dn;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [7:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      bus.sdi  = v[i];
      bus.sclk = 1'b0;
      repeat (3) tick;
      bus.sclk = 1'b1;
      repeat (3) tick;
    end
    bus.sclk = 1'b0;
  endtask

  task automatic pulse(input logic ld, input logic ll);
    bus.load   = ld;
    bus.ld_lim = ll;
    tick;
    bus.load   = 1'b0;
    bus.ld_lim = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.up   = tbl[i].up;
      bus.en   = tbl[i].en;
      bus.mode = tbl[i].mode;
      tick;
      chk($sformatf("vec%0d_count", i), bus.count, tbl[i].cnt);
      chk($sformatf("vec%0d_tc", i), 8'(bus.tc), 8'(tbl[i].tc));
      chk($sformatf("vec%0d_done", i), 8'(bus.done), 8'(tbl[i].dn));
    end
    bus.en = 1'b0;
  endtask

  initial begin
    // wrap up, lim=5, from 0 (0..7)
    tbl.push_back('{1, 1, 2'b00, 8'd1, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd2, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd3, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd4, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd5, 1, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd0, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd1, 0, 0});
    tbl.push_back('{1, 0, 2'b00, 8'd1, 0, 0});
    // saturate down, lim=5, from 3 (8..12)
    tbl.push_back('{0, 1, 2'b01, 8'd2, 0, 0});
    tbl.push_back('{0, 1, 2'b01, 8'd1, 0, 0});
    tbl.push_back('{0, 1, 2'b01, 8'd0, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 8'd0, 0, 0});
    tbl.push_back('{0, 1, 2'b01, 8'd0, 0, 0});
    // one-shot up, lim=3, from 0; mode change keeps done (13..18)
    tbl.push_back('{1, 1, 2'b10, 8'd1, 0, 0});
    tbl.push_back('{1, 1, 2'b10, 8'd2, 0, 0});
    tbl.push_back('{1, 1, 2'b10, 8'd3, 1, 0});
    tbl.push_back('{1, 1, 2'b10, 8'd3, 0, 1});
    tbl.push_back('{1, 1, 2'b10, 8'd3, 0, 1});
    tbl.push_back('{1, 1, 2'b00, 8'd3, 0, 1});
    // count above lim=3 from 9, then mode 11 down wrap (19..25)
    tbl.push_back('{1, 1, 2'b00, 8'd0, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd1, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd2, 0, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd3, 1, 0});
    tbl.push_back('{1, 1, 2'b00, 8'd0, 0, 0});
    tbl.push_back('{0, 1, 2'b11, 8'd3, 0, 0});
    tbl.push_back('{0, 1, 2'b11, 8'd2, 0, 0});

    {bus.load, bus.ld_lim, bus.sdi, bus.sclk, bus.up, bus.en, bus.oe} = '0;
    bus.mode = 2'b00;
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    bus.presc = 4'd0;
`endif
    #2;
    chk("rst_count", bus.count, 8'h00);
    chk("rst_tc", 8'(bus.tc), 8'h00);
    chk("rst_done", 8'(bus.done), 8'h00);
    chk("oeb_off", bus.count_oeb, 8'hff);
    tick;
    arst_n = 1'b1;
    tick;
    bus.oe = 1'b1;
    #1;
    chk("oeb_on", bus.count_oeb, 8'h00);

    bus.up = 1'b0; bus.en = 1'b1;
    tick;
    chk("rst_lim_wrap", bus.count, 8'hff);
    chk("rst_lim_tc", 8'(bus.tc), 8'h00);
    bus.en = 1'b0;

    shift_in(8'hA5, 8);
    pulse(1, 0);
    chk("load_a5", bus.count, 8'hA5);
    chk("load_tc", 8'(bus.tc), 8'h00);

    shift_in(8'h05, 8); pulse(0, 1);
    shift_in(8'h00, 8); pulse(1, 0);
    chk("load_zero", bus.count, 8'h00);
    run(0, 7);

    shift_in(8'h03, 8); pulse(1, 0);
    chk("load_three", bus.count, 8'h03);
    run(8, 12);

    shift_in(8'h03, 8); pulse(0, 1);
    shift_in(8'h00, 8); pulse(1, 0);
    run(13, 18);
    pulse(1, 0);
    chk("oneshot_clr_count", bus.count, 8'h00);
    chk("oneshot_clr_done", 8'(bus.done), 8'h00);

    shift_in(8'h09, 8); pulse(1, 0);
    chk("load_nine", bus.count, 8'h09);
    run(19, 25);

    // partial shift then reset: leftover bits must not survive
    shift_in(8'h0F, 4);
    bus.sdi = 1'b1; bus.sclk = 1'b1;
    tick;
    #2 arst_n = 1'b0;
    #1;
    chk("rst_shift_count", bus.count, 8'h00);
    chk("rst_shift_done", 8'(bus.done), 8'h00);
    chk("rst_shift_tc", 8'(bus.tc), 8'h00);
    bus.sclk = 1'b0; bus.sdi = 1'b0;
    tick;
    arst_n = 1'b1;
    tick;
    shift_in(8'h05, 4);
    pulse(1, 0);
    chk("shift_discard", bus.count, 8'h05);

    shift_in(8'h07, 8); pulse(0, 1);
    bus.up = 1'b1; bus.mode = 2'b10; bus.en = 1'b1;
    tick; chk("os_6", bus.count, 8'h06);
    tick; chk("os_7", bus.count, 8'h07); chk("os_7_tc", 8'(bus.tc), 8'h01);
    tick; chk("os_done", 8'(bus.done), 8'h01);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_cnt_count", bus.count, 8'h00);
    chk("rst_cnt_done", 8'(bus.done), 8'h00);
    chk("rst_cnt_tc", 8'(bus.tc), 8'h00);
    bus.en = 1'b0;
    tick;
    arst_n = 1'b1;
    bus.up = 1'b0; bus.mode = 2'b00; bus.en = 1'b1;
    tick;
    chk("rst_cnt_lim", bus.count, 8'hff);
    bus.en = 1'b0;
    bus.oe = 1'b0;
    #1;
    chk("oeb_off2", bus.count_oeb, 8'hff);

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    begin
      logic [7:0] pexp [8];
      logic       pen  [8];
      pexp = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
      pen  = '{1, 1, 1, 1, 0, 1, 1, 1};
      pulse(1, 0);
      bus.presc = 4'd2; bus.up = 1'b1; bus.mode = 2'b00;
      shift_in(8'h00, 8);
      pulse(1, 0);
      for (int i = 0; i < 8; i++) begin
        bus.en = pen[i];
        tick;
        chk($sformatf("presc%0d", i), bus.count, pexp[i]);
      end
      bus.en = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/shift/limit width (legal 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for sclk/sdi (legal 2..4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load  input  1  synchronous load of count from shift register.
REQ-006 ld_lim  input  1  synchronous load of limit register from shift register.
REQ-007 sdi  input  1  serial data, MSB-first.
REQ-008 sclk  input  1  asynchronous shift strobe, sampled by clk.
REQ-009 up  input  1  1 = count up, 0 = count down.
REQ-010 en  input  1  count enable.
REQ-011 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-012 oe  input  1  output enable.
REQ-013 count  output  WIDTH  counter value, always driven.
REQ-014 count_oeb  output  WIDTH  {WIDTH{~oe}}, 1 = hi-Z.
REQ-015 tc  output  1  registered terminal-count pulse.
REQ-016 done  output  1  one-shot completion flag.

Function
REQ-017 sclk and sdi SHALL each pass through SYNC_STAGES flops; a 0->1 on synchronised sclk SHALL shift: shreg <= {shreg[WIDTH-2:0], sdi_sync}.
REQ-018 Shift latency from sclk edge to shreg update SHALL be SYNC_STAGES+1 clk cycles; sclk high/low each held >= SYNC_STAGES+1 cycles.
REQ-019 load=1 SHALL set count <= shreg, clear done, clear prescaler; takes priority over counting.
REQ-020 ld_lim=1 SHALL set lim <= shreg; load and ld_lim together SHALL both occur from the same shreg value.
REQ-021 Counting range SHALL be 0..lim; count > lim (after load) SHALL be treated as at limit when counting up.
REQ-022 en=1, done=0, no load, up=1: count < lim -> count+1; count >= lim -> wrap: 0; saturate: hold; one-shot: hold, set done.
REQ-023 en=1, done=0, no load, up=0: count > 0 -> count-1; count == 0 -> wrap: lim; saturate: hold; one-shot: hold, set done.
REQ-024 done=1 SHALL freeze count until load or reset; mode change SHALL NOT clear done.
REQ-025 tc SHALL be 1 for exactly one cycle, the first cycle count holds lim (up) or 0 (down) after a counting step; not asserted by load, or while held at terminal.
REQ-026 lim change mid-count SHALL take effect on the next counting step; no count adjustment.
REQ-027 All arithmetic modulo 2^WIDTH internally; no out-of-range value SHALL be produced by counting.

Reset
REQ-028 arst_n=0 SHALL immediately clear count, shreg, synchronisers, prescaler, tc, done to 0 and set lim to all-ones.
REQ-029 Reset deassertion SHALL be honoured on the next clk edge; no edge detected on sclk from the reset state if sclk is 0.
REQ-030 Reset mid-shift SHALL discard partial shifted bits.

Configuration
REQ-031 Macro PROG_MOD_COUNTER_PRESCALE_EN defined: input presc [3:0] added; counting step SHALL occur on every (presc+1)-th enabled cycle; prescaler cleared on load, reset, and when en=0.
REQ-032 Macro undefined: presc port absent; counting step every enabled cycle.

Verification
REQ-033 Shift 8'hA5 MSB-first (WIDTH=8), pulse load -> count=8'hA5 next cycle, tc=0.
REQ-034 lim=5, mode=00, up=1, en=1 from 0 -> 1,2,3,4,5(tc=1),0,1; tc high exactly one cycle.
REQ-035 lim=5, mode=01, count=3, up=0 -> 2,1,0(tc=1),0,0; tc not repeated.
REQ-036 mode=10, up=1, lim=3 from 0 -> 1,2,3, done=1, count holds 3; load of 0 clears done.
REQ-037 arst_n pulsed low mid-shift and while counting -> count=0, lim=all-ones, done=0, tc=0 asynchronously; oe=0 -> count_oeb=all-ones.
REQ-038 PRESCALE_EN, presc=2, en=1 -> count advances every 3rd cycle; en dropped 1 cycle restarts prescale phase.
